// File: rtl/uart_tx_cfg.sv
// -----------------------------------------------------------------------------
// uart_tx_cfg
//   Parametrised UART transmitter. Serialises one word per frame, LSB first:
//   start bit, NBIT_DATA data bits, optional parity bit, then 1 or 2 stop bits.
//   A one-entry holding register accepts the next word while a frame is in
//   flight, so consecutive frames go out back-to-back with no idle bit.
//   The bit timing comes from the baud-rate generator's tick strobe.
//
// Ports
//   clk           system clock, all state updates on posedge
//   reset         asynchronous, active-high reset
//   tick          one-clk strobe from the baud-rate generator
//   tx_start      load request; data_in is valid in the same cycle
//   data_in       word to transmit
//   tx_ready      holding register empty (tx_start will be accepted)
//   tx_busy       frame in progress
//   tx_done_tick  one-clk pulse at the end of each frame's last stop bit
//   tx_bit        registered serial line, idles high
// -----------------------------------------------------------------------------
module uart_tx_cfg #(
  parameter int NBIT_DATA  = 8,
  parameter int NUM_TICKS  = 16,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 tx_start,
  input  logic [NBIT_DATA-1:0] data_in,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_done_tick,
  output logic                 tx_bit
);

  localparam int              TW        = $clog2(NUM_TICKS);
  localparam int              BW        = $clog2(NBIT_DATA);
  localparam logic [TW-1:0]   TICK_LAST = TW'(NUM_TICKS - 1);
  localparam logic [BW-1:0]   BIT_LAST  = BW'(NBIT_DATA - 1);
  localparam logic            STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic                 stop_cnt;
  logic [NBIT_DATA-1:0] shift_reg;
  logic [NBIT_DATA-1:0] hold_reg;
  logic                 parity_bit;

  logic bit_end;   // last tick of the current serial bit
  logic stop_end;  // last tick of the last stop bit
  logic transfer;  // hold register moves into the shifter this cycle

  assign bit_end  = tick && (tick_cnt == TICK_LAST);
  assign stop_end = bit_end && (state == S_STOP) && (stop_cnt == STOP_LAST);
  // tx_ready low means the holding register contains a word.
  assign transfer = !tx_ready && ((tick && (state == S_IDLE)) || stop_end);

  // Holding register. A load and a transfer cannot coincide: a load needs the
  // register empty, a transfer needs it full.
  // NOTE: the holding register is reset as well, so a word loaded before reset
  // can never leak into a frame sent after it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_reg <= '0;
      tx_ready <= 1'b1;
    end else if (tx_start && tx_ready) begin
      hold_reg <= data_in;
      tx_ready <= 1'b0;
    end else if (transfer) begin
      tx_ready <= 1'b1;
    end
  end

  // Frame sequencer. All outputs are registered and only move on tick cycles,
  // except the done pulse which is cleared on the following clk.
  // NOTE: non-blocking assignments throughout, so every branch reads the
  // pre-edge value of state/counters regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      stop_cnt     <= 1'b0;
      shift_reg    <= '0;
      parity_bit   <= 1'b0;
      tx_bit       <= 1'b1;
      tx_busy      <= 1'b0;
      tx_done_tick <= 1'b0;
    end else begin
      tx_done_tick <= 1'b0;
      if (tick) begin
        tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;
        case (state)
          S_IDLE: begin
            tick_cnt <= '0;
            tx_bit   <= 1'b1;
            if (!tx_ready) begin
              shift_reg  <= hold_reg;
              parity_bit <= (^hold_reg) ^ PARITY_ODD;
              tx_bit     <= 1'b0;
              tx_busy    <= 1'b1;
              state      <= S_START;
            end
          end

          S_START: begin
            if (bit_end) begin
              bit_cnt <= '0;
              tx_bit  <= shift_reg[0];
              state   <= S_DATA;
            end
          end

          S_DATA: begin
            if (bit_end) begin
              if (bit_cnt == BIT_LAST) begin
                if (PARITY_EN) begin
                  tx_bit <= parity_bit;
                  state  <= S_PARITY;
                end else begin
                  stop_cnt <= 1'b0;
                  tx_bit   <= 1'b1;
                  state    <= S_STOP;
                end
              end else begin
                shift_reg <= shift_reg >> 1;
                tx_bit    <= shift_reg[1];
                bit_cnt   <= bit_cnt + 1'b1;
              end
            end
          end

          S_PARITY: begin
            if (bit_end) begin
              stop_cnt <= 1'b0;
              tx_bit   <= 1'b1;
              state    <= S_STOP;
            end
          end

          S_STOP: begin
            if (bit_end) begin
              if (stop_cnt == STOP_LAST) begin
                tx_done_tick <= 1'b1;
                if (!tx_ready) begin
                  // Chain straight into the next frame's start bit.
                  shift_reg  <= hold_reg;
                  parity_bit <= (^hold_reg) ^ PARITY_ODD;
                  tx_bit     <= 1'b0;
                  state      <= S_START;
                end else begin
                  tx_bit  <= 1'b1;
                  tx_busy <= 1'b0;
                  state   <= S_IDLE;
                end
              end else begin
                stop_cnt <= stop_cnt + 1'b1;
              end
            end
          end

          default: begin
            tick_cnt <= '0;
            tx_bit   <= 1'b1;
            tx_busy  <= 1'b0;
            state    <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_cfg
//   Five transmitters with different frame formats share clk, reset and a
//   tick strobe every 4 clk. A frame-level model (word -> bit vector, tick
//   position within the frame) predicts every output on every cycle; directed
//   tests add hand-computed frame images, frame lengths and done counts.
//   Instances: 0 8N1/16, 1 8E1/16, 2 8O1/16, 3 8N2/16, 4 5N1/8.
// -----------------------------------------------------------------------------
module tb_uart_tx_cfg;

  localparam int NI = 5;
  localparam int C_NB [NI] = '{8, 8, 8, 8, 5};
  localparam int C_NT [NI] = '{16, 16, 16, 16, 8};
  localparam int C_PE [NI] = '{0, 1, 1, 0, 0};
  localparam int C_PO [NI] = '{0, 0, 1, 0, 0};
  localparam int C_SB [NI] = '{1, 1, 1, 2, 1};

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          tick = 1'b0;
  logic [NI-1:0] start_v = '0;
  logic [8:0]    din [NI];
  logic [NI-1:0] txb, rdy, bsy, dn;

  int n_cmp = 0;
  int n_bad = 0;
  int dn_cnt [NI];

  // Model state
  bit          m_full [NI];
  logic [8:0]  m_word [NI];
  bit          m_in   [NI];
  int          m_pos  [NI];
  logic [15:0] m_frame[NI];
  bit          m_done [NI];
  bit          m_line [NI];

  initial forever #5 clk = ~clk;

  initial begin
    forever begin
      repeat (3) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  end

  uart_tx_cfg #(.NBIT_DATA(8), .NUM_TICKS(16), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1)) u0 (
    .clk(clk), .reset(reset), .tick(tick), .tx_start(start_v[0]), .data_in(din[0][7:0]),
    .tx_ready(rdy[0]), .tx_busy(bsy[0]), .tx_done_tick(dn[0]), .tx_bit(txb[0]));
  uart_tx_cfg #(.NBIT_DATA(8), .NUM_TICKS(16), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(1)) u1 (
    .clk(clk), .reset(reset), .tick(tick), .tx_start(start_v[1]), .data_in(din[1][7:0]),
    .tx_ready(rdy[1]), .tx_busy(bsy[1]), .tx_done_tick(dn[1]), .tx_bit(txb[1]));
  uart_tx_cfg #(.NBIT_DATA(8), .NUM_TICKS(16), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(1)) u2 (
    .clk(clk), .reset(reset), .tick(tick), .tx_start(start_v[2]), .data_in(din[2][7:0]),
    .tx_ready(rdy[2]), .tx_busy(bsy[2]), .tx_done_tick(dn[2]), .tx_bit(txb[2]));
  uart_tx_cfg #(.NBIT_DATA(8), .NUM_TICKS(16), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(2)) u3 (
    .clk(clk), .reset(reset), .tick(tick), .tx_start(start_v[3]), .data_in(din[3][7:0]),
    .tx_ready(rdy[3]), .tx_busy(bsy[3]), .tx_done_tick(dn[3]), .tx_bit(txb[3]));
  uart_tx_cfg #(.NBIT_DATA(5), .NUM_TICKS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1)) u4 (
    .clk(clk), .reset(reset), .tick(tick), .tx_start(start_v[4]), .data_in(din[4][4:0]),
    .tx_ready(rdy[4]), .tx_busy(bsy[4]), .tx_done_tick(dn[4]), .tx_bit(txb[4]));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got timeout, expected event within cycle budget (t=%0t)", nm, $time);
  endtask

  function automatic int flen(input int i);
    return 1 + C_NB[i] + C_PE[i] + C_SB[i];
  endfunction

  // Frame image, bit k = line level during the k-th serial bit.
  function automatic logic [15:0] build(input int i, input logic [8:0] w);
    logic [15:0] f;
    logic        par;
    f    = '1;
    f[0] = 1'b0;
    par  = (C_PO[i] != 0);
    for (int k = 0; k < C_NB[i]; k++) begin
      f[1+k] = w[k];
      par    = par ^ w[k];
    end
    if (C_PE[i] != 0) f[1+C_NB[i]] = par;
    return f;
  endfunction

  task automatic model_step();
    bit was_empty;
    for (int i = 0; i < NI; i++) begin
      if (reset) begin
        m_full[i] = 1'b0;
        m_in[i]   = 1'b0;
        m_pos[i]  = 0;
        m_done[i] = 1'b0;
        m_line[i] = 1'b1;
      end else begin
        was_empty = !m_full[i];
        m_done[i] = 1'b0;
        if (tick) begin
          if (m_in[i]) begin
            m_pos[i]++;
            if (m_pos[i] == C_NT[i] * flen(i)) begin
              m_done[i] = 1'b1;
              m_in[i]   = 1'b0;
            end
          end
          if (!m_in[i] && m_full[i]) begin
            m_frame[i] = build(i, m_word[i]);
            m_pos[i]   = 0;
            m_in[i]    = 1'b1;
            m_full[i]  = 1'b0;
          end
        end
        if (start_v[i] && was_empty) begin
          m_word[i] = din[i];
          m_full[i] = 1'b1;
        end
        m_line[i] = m_in[i] ? m_frame[i][m_pos[i] / C_NT[i]] : 1'b1;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      m_full[i] = 1'b0; m_in[i] = 1'b0; m_pos[i] = 0; m_done[i] = 1'b0;
      m_line[i] = 1'b1; m_word[i] = '0; m_frame[i] = '1;
    end
    forever begin
      @(posedge clk or posedge reset);
      model_step();
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    for (int i = 0; i < NI; i++) dn_cnt[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        check($sformatf("u%0d_tx_bit", i),   32'(txb[i]), 32'(m_line[i]));
        check($sformatf("u%0d_tx_ready", i), 32'(rdy[i]), 32'(!m_full[i]));
        check($sformatf("u%0d_tx_busy", i),  32'(bsy[i]), 32'(m_in[i]));
        check($sformatf("u%0d_tx_done", i),  32'(dn[i]),  32'(m_done[i]));
        if (dn[i]) dn_cnt[i]++;
      end
    end
  end

  task automatic send(input int i, input logic [8:0] w);
    @(negedge clk);
    start_v[i] = 1'b1;
    din[i]     = w;
    @(negedge clk);
    start_v[i] = 1'b0;
    din[i]     = ~w;  // later changes to data_in must not matter
  endtask

  // Waits for a start bit, then samples each serial bit at mid-bit and counts
  // ticks from the start edge up to the edge that raises tx_done_tick.
  task automatic capture(input int i, output logic [15:0] bits, output int ticks);
    int  guard;
    bit  got;
    bits  = '0;
    ticks = 0;
    guard = 0;
    while (txb[i] !== 1'b0 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 3000) begin
      timeout_fail($sformatf("u%0d_start_bit", i));
      return;
    end
    guard = 0;
    while (guard < 4000) begin
      @(posedge clk);
      got = tick;
      @(negedge clk);
      guard++;
      if (got) begin
        ticks++;
        if ((ticks % C_NT[i]) == C_NT[i] / 2 && ticks / C_NT[i] < 16)
          bits[ticks / C_NT[i]] = txb[i];
      end
      if (dn[i]) break;
    end
    if (guard >= 4000) timeout_fail($sformatf("u%0d_done_pulse", i));
  endtask

  initial begin
    logic [15:0] bits;
    int          ticks;
    int          d0;

    for (int i = 0; i < NI; i++) din[i] = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("u%0d_reset_tx_bit", i), 32'(txb[i]), 32'd1);
      check($sformatf("u%0d_reset_ready", i),  32'(rdy[i]), 32'd1);
      check($sformatf("u%0d_reset_busy", i),   32'(bsy[i]), 32'd0);
      check($sformatf("u%0d_reset_done", i),   32'(dn[i]),  32'd0);
    end

    // 8N1: 0xA5 -> 0,1,0,1,0,0,1,0,1,1
    d0 = dn_cnt[0];
    send(0, 9'h0A5);
    check("8n1_ready_after_load", 32'(rdy[0]), 32'd0);
    capture(0, bits, ticks);
    check("8n1_a5_frame", 32'(bits[9:0]), 32'h34A);
    check("8n1_frame_ticks", 32'(ticks), 32'd160);
    repeat (2) @(negedge clk);
    check("8n1_done_count", 32'(dn_cnt[0] - d0), 32'd1);
    check("8n1_idle_line", 32'(txb[0]), 32'd1);

    // 8E1 / 8O1: 0x07 -> parity 1 (even) / 0 (odd)
    send(1, 9'h007);
    capture(1, bits, ticks);
    check("8e1_parity_bit", 32'(bits[9]), 32'd1);
    check("8e1_frame", 32'(bits[10:0]), 32'h60E);
    check("8e1_frame_ticks", 32'(ticks), 32'd176);
    send(2, 9'h007);
    capture(2, bits, ticks);
    check("8o1_parity_bit", 32'(bits[9]), 32'd0);
    check("8o1_frame", 32'(bits[10:0]), 32'h40E);
    check("8o1_frame_ticks", 32'(ticks), 32'd176);

    // 8N2 back-to-back: 0x3C, then 0xC3 loaded mid-frame, 0xFF refused
    d0 = dn_cnt[3];
    send(3, 9'h03C);
    fork
      capture(3, bits, ticks);
      begin
        repeat (300) @(negedge clk);
        check("8n2_ready_in_data", 32'(rdy[3]), 32'd1);
        send(3, 9'h0C3);
        check("8n2_ready_after_2nd_load", 32'(rdy[3]), 32'd0);
        send(3, 9'h0FF);
        check("8n2_ready_after_refused", 32'(rdy[3]), 32'd0);
      end
    join
    check("8n2_first_frame", 32'(bits[10:0]), 32'h678);
    check("8n2_first_ticks", 32'(ticks), 32'd176);
    check("8n2_chain_start_bit", 32'(txb[3]), 32'd0);
    check("8n2_chain_busy", 32'(bsy[3]), 32'd1);
    capture(3, bits, ticks);
    check("8n2_second_frame", 32'(bits[10:0]), 32'h786);
    check("8n2_second_ticks", 32'(ticks), 32'd176);
    repeat (200) @(negedge clk);
    check("8n2_done_count", 32'(dn_cnt[3] - d0), 32'd2);
    check("8n2_no_third_frame", 32'(bsy[3]), 32'd0);
    check("8n2_final_idle", 32'(txb[3]), 32'd1);

    // Asynchronous reset in the middle of DATA
    send(0, 9'h0A5);
    ticks = 0;
    while (txb[0] !== 1'b0 && ticks < 100) begin
      @(negedge clk);
      ticks++;
    end
    if (ticks >= 100) timeout_fail("rst_wait_start");
    repeat (100) @(negedge clk);
    check("rst_pre_busy", 32'(bsy[0]), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_async_tx_bit", 32'(txb[0]), 32'd1);
    check("rst_async_ready", 32'(rdy[0]), 32'd1);
    check("rst_async_busy", 32'(bsy[0]), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    d0 = dn_cnt[0];
    send(0, 9'h055);
    capture(0, bits, ticks);
    check("rst_after_55_frame", 32'(bits[9:0]), 32'h2AA);
    check("rst_after_55_ticks", 32'(ticks), 32'd160);
    repeat (2) @(negedge clk);
    check("rst_after_done_count", 32'(dn_cnt[0] - d0), 32'd1);

    // 5N1, 8 ticks per bit: 0x1F -> 7-bit frame, 56 ticks
    send(4, 9'h01F);
    capture(4, bits, ticks);
    check("5n1_frame", 32'(bits[7:0]), 32'h7E);
    check("5n1_frame_ticks", 32'(ticks), 32'd56);

    repeat (10) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation time limit, expected test completion");
    $fatal(1, "watchdog expired");
  end

endmodule
